// File: rtl/shop_pkg.sv
// rtl/shop_pkg.sv - shared constants, state encoding and cost table for the purchase arbiter
package shop_pkg;
    localparam int NREQ = 4;
    localparam int CW   = 12;
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, SAMPLE, RESP} state_e;

    localparam logic [CW-1:0] COST [NREQ] = '{12'd10, 12'd25, 12'd60, 12'd150};

    function automatic logic [CW-1:0] cost_of(input logic [IW-1:0] idx);
        return COST[idx];
    endfunction
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin selector: first set request at or after ptr, wrapping
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   grant,
    output logic            valid
);
    logic [PW-1:0] idx;

    // Scan from the farthest offset down so the nearest set bit wins last.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % NREQ);
            if (req[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/purchase_arbiter.sv
// rtl/purchase_arbiter.sv - round-robin arbiter sequencing wallet purchases for NREQ requesters
module purchase_arbiter #(
    parameter int NREQ = shop_pkg::NREQ,
    parameter int CW   = shop_pkg::CW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            gameTick,
    input  logic [NREQ-1:0] req,
    input  logic [CW-1:0]   balance,
    input  logic            buySucc,
    output logic            purchase,
    output logic [CW-1:0]   unitCost,
    output logic [NREQ-1:0] done,
    output logic            ok,
    output logic            busy
);
    import shop_pkg::*;

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic [PW-1:0] pick;
    logic          pick_valid;
    logic [CW-1:0] cost;
    logic          armed;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .grant (pick),
        .valid (pick_valid)
    );

    assign busy = (state != IDLE);

    // armed holds off arbitration until the second edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            win      <= '0;
            cost     <= '0;
            purchase <= 1'b0;
            unitCost <= '0;
            done     <= '0;
            ok       <= 1'b0;
            armed    <= 1'b0;
        end else begin
            armed <= 1'b1;
            done  <= '0;
            case (state)
                IDLE: begin
                    if (armed && pick_valid) begin
                        win   <= pick;
                        cost  <= CW'(cost_of(IW'(pick)));
                        ok    <= 1'b0;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (balance < cost) begin
                        ok    <= 1'b0;
                        state <= RESP;
                    end else begin
                        purchase <= 1'b1;
                        unitCost <= cost;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (gameTick) begin
                        purchase <= 1'b0;
                        unitCost <= '0;
                        state    <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    ok    <= (buySucc === 1'b1);
                    state <= RESP;
                end
                RESP: begin
                    done[win] <= 1'b1;
                    ptr       <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_purchase_arbiter.sv
// tb/tb_purchase_arbiter.sv - self-checking bench for purchase_arbiter
module tb_purchase_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        gameTick;
    logic [3:0]  req;
    logic [11:0] balance;
    logic        buySucc;
    logic        purchase;
    logic [11:0] unitCost;
    logic [3:0]  done;
    logic        ok;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int mptr  = 0;
    int cost_t [4] = '{10, 25, 60, 150};

    typedef struct {
        logic [3:0] mask;
        int         bal;
        bit         succ;
        int         t1;
        int         t2;
        bit         hold;
        bit         drop;
        logic [3:0] exp_done;
        bit         exp_ok;
    } vec_t;

    vec_t tbl [11];

    always #5 clk = ~clk;

    purchase_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .gameTick (gameTick),
        .req      (req),
        .balance  (balance),
        .buySucc  (buySucc),
        .purchase (purchase),
        .unitCost (unitCost),
        .done     (done),
        .ok       (ok),
        .busy     (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [3:0] m, input int p);
        int q;
        for (int k = 0; k < 4; k++) begin
            q = (p + k) % 4;
            if (m[q[1:0]]) return q;
        end
        return 0;
    endfunction

    // Ticks are given as the edge number (edge 1 latches the request) at which gameTick is sampled.
    task automatic run_txn(input string name, input logic [3:0] mask, input int bal, input bit succ,
                           input int t1, input int t2, input bit hold, input bit drop,
                           input logic [3:0] exp_done, input bit exp_ok);
        int w, tk, exp_lat;
        bit refuse, p_exp, seen;
        seen    = 1'b0;
        w       = pick(mask, mptr);
        refuse  = bal < cost_t[w];
        tk      = (t1 >= 3) ? t1 : t2;
        exp_lat = refuse ? 3 : tk + 2;
        req      = mask;
        balance  = 12'(bal);
        gameTick = 1'b0;
        buySucc  = 1'b0;
        for (int k = 1; k <= 80 && !seen; k++) begin
            step();
            p_exp = !refuse && k >= 2 && k < tk;
            check({name, " purchase"}, int'(purchase), int'(p_exp));
            check({name, " unitCost"}, int'(unitCost), p_exp ? cost_t[w] : 0);
            if (k == 1) check({name, " busy"}, int'(busy), 1);
            if (done != 4'b0000) begin
                seen = 1'b1;
                mptr = (w + 1) % 4;
                check({name, " done"}, int'(done), int'(exp_done));
                check({name, " ok"}, int'(ok), int'(exp_ok));
                check({name, " latency"}, k, exp_lat);
                check({name, " ptr"}, int'(dut.ptr), mptr);
                if (!hold) req = 4'b0000;
            end
            if (drop && k == 1) req = 4'b0000;
            gameTick = (k + 1 == t1) || (k + 1 == t2);
            buySucc  = (k == tk) ? succ : 1'b0;
        end
        if (!seen) check({name, " done timeout"}, 0, 1);
        gameTick = 1'b0;
        buySucc  = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{4'b1111, 4095, 1'b1, 3, 0, 1'b1, 1'b0, 4'b0001, 1'b1};
        tbl[1]  = '{4'b1111, 4095, 1'b1, 3, 0, 1'b1, 1'b0, 4'b0010, 1'b1};
        tbl[2]  = '{4'b1111, 4095, 1'b1, 3, 0, 1'b1, 1'b0, 4'b0100, 1'b1};
        tbl[3]  = '{4'b1111, 4095, 1'b1, 3, 0, 1'b1, 1'b0, 4'b1000, 1'b1};
        tbl[4]  = '{4'b1111, 4095, 1'b1, 3, 0, 1'b0, 1'b0, 4'b0001, 1'b1};
        tbl[5]  = '{4'b0001, 100,  1'b1, 6, 0, 1'b0, 1'b0, 4'b0001, 1'b1};
        tbl[6]  = '{4'b0100, 20,   1'b1, 3, 0, 1'b0, 1'b0, 4'b0100, 1'b0};
        tbl[7]  = '{4'b0010, 200,  1'b0, 3, 0, 1'b0, 1'b1, 4'b0010, 1'b0};
        tbl[8]  = '{4'b0001, 100,  1'b1, 2, 5, 1'b0, 1'b0, 4'b0001, 1'b1};
        tbl[9]  = '{4'b0110, 24,   1'b1, 3, 0, 1'b0, 1'b0, 4'b0010, 1'b0};
        tbl[10] = '{4'b1000, 150,  1'b1, 4, 0, 1'b0, 1'b0, 4'b1000, 1'b1};

        rst_n    = 1'b0;
        gameTick = 1'b0;
        req      = 4'b0000;
        balance  = 12'd0;
        buySucc  = 1'b0;
        #1;
        check("reset purchase", int'(purchase), 0);
        check("reset unitCost", int'(unitCost), 0);
        check("reset done", int'(done), 0);
        check("reset ok", int'(ok), 0);
        check("reset busy", int'(busy), 0);
        check("reset ptr", int'(dut.ptr), 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 11; i++)
            run_txn($sformatf("vec%0d", i), tbl[i].mask, tbl[i].bal, tbl[i].succ, tbl[i].t1, tbl[i].t2,
                    tbl[i].hold, tbl[i].drop, tbl[i].exp_done, tbl[i].exp_ok);

        for (int i = 0; i < 40; i++) begin
            logic [3:0] m;
            int b, t1, t2, w;
            bit s;
            m  = 4'($urandom_range(1, 15));
            b  = $urandom_range(0, 200);
            s  = 1'($urandom_range(0, 1));
            t1 = $urandom_range(2, 6);
            t2 = t1 + $urandom_range(1, 3);
            w  = pick(m, mptr);
            run_txn($sformatf("rnd%0d", i), m, b, s, t1, t2, 1'b0, 1'b0,
                    4'(1 << w), (b >= cost_t[w]) && s);
            repeat ($urandom_range(0, 2)) step();
        end

        req     = 4'b0001;
        balance = 12'd100;
        repeat (3) step();
        check("rst pre purchase", int'(purchase), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst purchase", int'(purchase), 0);
        check("rst unitCost", int'(unitCost), 0);
        check("rst busy", int'(busy), 0);
        check("rst ptr", int'(dut.ptr), 0);
        req     = 4'b0010;
        balance = 12'd0;
        for (int k = 0; k < 2; k++) begin
            step();
            check("rst no done", int'(done), 0);
        end
        rst_n = 1'b1;
        mptr  = 0;
        step();
        check("rst first edge idle", int'(busy), 0);
        step();
        check("rst second edge busy", int'(busy), 1);
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 10 && !seen; k++) begin
                step();
                if (done != 4'b0000) begin
                    seen = 1'b1;
                    check("rst restart done", int'(done), 4'b0010);
                    check("rst restart ok", int'(ok), 0);
                    req = 4'b0000;
                end
            end
            if (!seen) check("rst restart timeout", 0, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/purchase_arbiter.md
PURCHASE_ARBITER -- requirements
Module: purchase_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of purchase requesters.
REQ-002 SHALL have parameter CW, default 12: cost and balance width.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port gameTick, input, 1: one-clk pulse, clk-synchronous, marking the wallet update edge.
REQ-006 SHALL have port req, input, NREQ: level requests; each bit is held high until its done bit pulses.
REQ-007 SHALL have port balance, input, CW: current wallet balance.
REQ-008 SHALL have port buySucc, input, 1: wallet purchase result, valid in the clk cycle after gameTick.
REQ-009 SHALL have port purchase, output, 1: purchase strobe to the wallet.
REQ-010 SHALL have port unitCost, output, CW: cost presented to the wallet.
REQ-011 SHALL have port done, output, NREQ: one-hot, one-clk completion pulse to the served requester.
REQ-012 SHALL have port ok, output, 1: qualifies done; 1 = bought, 0 = refused.
REQ-013 SHALL have port busy, output, 1: high in every state other than IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, CHECK, ISSUE, SAMPLE and RESP.
REQ-015 IDLE: when any req bit is high, SHALL latch the round-robin winner (the first set bit at or after ptr, wrapping) and its cost from the cost table, then go to CHECK.
REQ-016 CHECK, one clk: if balance < cost, SHALL go to RESP with ok=0 and never assert purchase; otherwise SHALL go to ISSUE.
REQ-017 ISSUE: SHALL hold purchase=1 and unitCost=cost until gameTick is sampled high, then go to SAMPLE.
REQ-018 SAMPLE, one clk: SHALL deassert purchase, capture buySucc as ok, and go to RESP.
REQ-019 RESP, one clk: SHALL assert done[winner]=1 with ok valid, set ptr=(winner+1) mod NREQ, and go to IDLE.
REQ-020 unitCost SHALL be 0 whenever purchase is 0.
REQ-021 Arbitration latency SHALL be: req to done = 3 clk for a refusal; for a purchase, 4 clk plus the wait for gameTick.
REQ-022 The winner SHALL be committed once latched: a req drop after IDLE SHALL NOT abort the sequence, and done SHALL still pulse.
REQ-023 If gameTick coincides with the CHECK-to-ISSUE transition, it SHALL NOT be consumed; only a tick sampled while in ISSUE counts.
REQ-024 A requester SHALL be re-eligible on the clk after its done pulse; a req still high then is treated as a new request.
REQ-025 Simultaneous requests SHALL be served one per sequence in rotation, with no requester starved beyond NREQ-1 sequences.
REQ-026 The cost comparison SHALL be unsigned at CW bits; a cost of 0 SHALL always pass CHECK.
REQ-027 If buySucc is X or Z in SAMPLE, ok SHALL be forced to 0.

Reset
REQ-028 rst_n low SHALL asynchronously force: state=IDLE, ptr=0, purchase=0, unitCost=0, done=0, ok=0, busy=0.
REQ-029 Reset asserted mid-ISSUE SHALL drop purchase immediately and emit no done pulse.
REQ-030 After rst_n deasserts, the first arbitration SHALL occur no earlier than the second rising edge.

Structure
REQ-031 The shared package shop_pkg SHALL hold the state encoding, NREQ, CW, and the cost table COST[0..NREQ-1] (defaults 10, 25, 60, 150).
REQ-032 The round-robin selector SHALL be a sub-module rr_pick (inputs req and ptr; outputs grant index and valid).

Verification
REQ-033 Bench SHALL check: balance=100, req=0001, buySucc=1 at tick -> purchase held until tick with unitCost=10, then done=0001, ok=1.
REQ-034 Bench SHALL check: balance=20, req=0100 (cost 60) -> done=0100, ok=0 after 3 clk, with purchase never high.
REQ-035 Bench SHALL check: req=1111 held continuously with balance=4095 -> grant order 0, 1, 2, 3, 0.
REQ-036 Bench SHALL check: balance=200, req=0010, buySucc=0 -> done=0010, ok=0, and ptr advances to 2.
REQ-037 Bench SHALL check: rst_n pulled low while in ISSUE -> purchase=0 in the same cycle, no done pulse, and the FSM restarts from IDLE with ptr=0.
REQ-038 Bench SHALL check: gameTick on the CHECK-to-ISSUE edge -> no sampling on that tick, and purchase held until the next tick.
